// File: rtl/rf_port_arbiter_if.sv
// Client-side bus of rf_port_arbiter: per-port request/op/address/write data in,
// combinational one-hot grant and shared read-return out.
interface rf_port_arbiter_if #(
  parameter int NPORTS = 4,
  parameter int DW     = 32,
  parameter int AW     = 4
);
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    we;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS*DW-1:0] wdata;
  logic [NPORTS-1:0]    gnt;
  logic [NPORTS-1:0]    rvalid;
  logic [DW-1:0]        rdata;

  // master: the client ports; slave: the arbiter
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/rf_port_arbiter.sv
// Shares one register file among NPORTS clients; RF_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
// Command registered 1 cycle after grant, read data 2 cycles after; a losing port stalls by holding req.
module rf_port_arbiter #(
  parameter int NPORTS = 4,
  parameter int DW     = 32,
  parameter int AW     = 4
) (
  input  logic                clk0,
  input  logic                reset,
  rf_port_arbiter_if.slave    bus,
  output logic                rf_wr_en,
  output logic [AW-1:0]       rf_wr_addr,
  output logic [DW-1:0]       rf_wr_data,
  output logic                rf_rd_en,
  output logic [AW-1:0]       rf_rd_addr,
  input  logic [DW-1:0]       rf_rd_data
);
  localparam int IW = $clog2(NPORTS);

  logic [NPORTS-1:0] gnt_c;
  logic [IW-1:0]     gnt_idx;
  logic              accept;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;

  logic              tag1_vld;
  logic [IW-1:0]     tag1_idx;
  logic              tag2_vld;
  logic [IW-1:0]     tag2_idx;
  logic [NPORTS-1:0] rvalid_q;
  logic [DW-1:0]     rdata_q;

`ifdef RF_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] scan_idx;
  logic          found;

  // Scan from the pointer upward with wrap; first requester wins.
  always_comb begin
    gnt_c    = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      scan_idx = IW'((int'(ptr_q) + k) % NPORTS);
      if (!found && bus.req[scan_idx]) begin
        gnt_c[scan_idx] = 1'b1;
        found           = 1'b1;
      end
    end
    if (!reset) begin
      gnt_c = '0;
    end
  end

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (gnt_idx == IW'(NPORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  // Isolate the lowest set request bit.
  always_comb begin
    gnt_c = '0;
    if (reset) begin
      gnt_c = bus.req & (~bus.req + 1'b1);
    end
  end
`endif

  assign bus.gnt = gnt_c;
  assign accept  = |gnt_c;

  always_comb begin
    gnt_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (gnt_c[i]) begin
        gnt_idx   = IW'(i);
        sel_we    = bus.we[i];
        sel_addr  = bus.addr[i*AW +: AW];
        sel_wdata = bus.wdata[i*DW +: DW];
      end
    end
  end

  // Address/data registers only load on their own op so they hold when idle.
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      rf_rd_addr <= '0;
    end else begin
      rf_wr_en <= accept & sel_we;
      rf_rd_en <= accept & ~sel_we;
      if (accept && sel_we) begin
        rf_wr_addr <= sel_addr;
        rf_wr_data <= sel_wdata;
      end
      if (accept && !sel_we) begin
        rf_rd_addr <= sel_addr;
      end
    end
  end

  // Tag stage 1 tracks the RF command cycle, stage 2 the RF data cycle.
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      tag1_vld <= 1'b0;
      tag1_idx <= '0;
      tag2_vld <= 1'b0;
      tag2_idx <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      tag1_vld <= accept & ~sel_we;
      if (accept && !sel_we) begin
        tag1_idx <= gnt_idx;
      end
      tag2_vld <= tag1_vld;
      tag2_idx <= tag1_idx;
      rvalid_q <= '0;
      if (tag2_vld) begin
        rvalid_q[tag2_idx] <= 1'b1;
        rdata_q            <= rf_rd_data;
      end
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

  a_cmd_exclusive: assert property (@(posedge clk0) disable iff (!reset)
    !(rf_wr_en && rf_rd_en));
  a_gnt_onehot: assert property (@(posedge clk0) disable iff (!reset)
    $onehot0(bus.gnt));
  a_gnt_on_req: assert property (@(posedge clk0) disable iff (!reset)
    (bus.gnt & ~bus.req) == '0);
endmodule
